// File: rtl/video_row_fetcher.sv
// video_row_fetcher: fetches one text row of charattr words per burst from
// SDRAM into a double-buffered line store. The display side reads the
// display bank while the next row is filled into the other bank.
module video_row_fetcher #(
  parameter int COLUMNS     = 80,
  parameter int ROWS        = 51,
  parameter int CHAR_HEIGHT = 20,
  parameter int ROW_SIZE    = 80,
  parameter int PAGE_SIZE   = 4080,
  parameter int ADDR_WIDTH  = 23
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic                           line_end,
  input  logic [ADDR_WIDTH-1:0]          base_address,
  input  logic [ADDR_WIDTH-1:0]          first_row,
  output logic                           rd_request,
  output logic [ADDR_WIDTH-1:0]          rd_address,
  output logic [8:0]                     rd_burst_length,
  input  logic                           rd_available,
  input  logic [31:0]                    rd_data,
  input  logic [$clog2(COLUMNS)-1:0]     buf_rd_index,
  output logic [31:0]                    buf_rd_data,
  output logic [$clog2(CHAR_HEIGHT)-1:0] char_row,
  output logic                           underrun
);

  localparam int IDX_W = $clog2(COLUMNS);
  localparam int CR_W  = $clog2(CHAR_HEIGHT);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(COLUMNS - 1);
  localparam logic [CR_W-1:0]  LAST_LINE = CR_W'(CHAR_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, REQUEST, RECEIVE, DONE, DRAIN} state_t;

  state_t                 state;
  logic                   disp_bank;
  logic [IDX_W-1:0]       wr_index;
  logic [ROW_W-1:0]       row_cnt;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [ADDR_WIDTH-1:0]  first_q;
  logic [31:0]            bank_mem [2][COLUMNS];

  // Ring advance: one extra bit so the sum can never overflow before the compare.
  function automatic logic [ADDR_WIDTH-1:0] next_row_addr(input logic [ADDR_WIDTH-1:0] cur,
                                                          input logic [ADDR_WIDTH-1:0] base);
    logic [AW1-1:0] sum;
    logic [AW1-1:0] limit;
    sum   = {1'b0, cur} + AW1'(ROW_SIZE);
    limit = {1'b0, base} + AW1'(PAGE_SIZE);
    return (sum >= limit) ? base : sum[ADDR_WIDTH-1:0];
  endfunction

  logic                  last_word;
  logic                  last_line;
  logic                  bank_we;
  logic                  swap_line;
  logic                  swap_first;
  logic                  start_idle;
  logic                  start_drain;
  logic                  do_start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ROW_W-1:0]      row_next;
  logic                  more_rows;

  assign last_word  = (wr_index == LAST_WORD);
  assign last_line  = (char_row == LAST_LINE);
  assign bank_we    = (state == RECEIVE) && rd_available && !frame_start;
  assign swap_line  = line_end && !frame_start && last_line &&
                      (state == REQUEST || state == RECEIVE || state == DONE);
  // First row of a frame goes straight to the display bank once complete.
  assign swap_first = bank_we && last_word && (row_cnt == '0);
  assign start_idle = frame_start && (state == IDLE || state == DONE);
  // A burst interrupted by frame_start restarts only after its last word is discarded.
  assign start_drain = rd_available && last_word &&
                       ((state == DRAIN) || (state == RECEIVE && frame_start));
  assign do_start   = start_idle || start_drain;
  assign start_addr = frame_start ? first_row : first_q;
  assign row_next   = row_cnt + 1'b1;
  assign more_rows  = int'(row_next) < ROWS;

  assign rd_burst_length = 9'(COLUMNS);

  // Fetch sequencer: frame start, burst tracking, scanline counting and bank swaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_request <= 1'b0;
      rd_address <= '0;
      char_row   <= '0;
      underrun   <= 1'b0;
      disp_bank  <= 1'b1;
      wr_index   <= '0;
      row_cnt    <= '0;
      base_q     <= '0;
      first_q    <= '0;
    end else begin
      rd_request <= 1'b0;
      if (frame_start) begin
        base_q  <= base_address;
        first_q <= first_row;
      end
      if (swap_line || swap_first) disp_bank <= ~disp_bank;

      if (do_start) begin
        state      <= REQUEST;
        rd_request <= 1'b1;
        rd_address <= start_addr;
        wr_index   <= '0;
        row_cnt    <= '0;
        char_row   <= '0;
        underrun   <= 1'b0;
      end else if (frame_start && (state == REQUEST || state == RECEIVE || state == DRAIN)) begin
        state <= DRAIN;
        if (state == RECEIVE && rd_available) wr_index <= wr_index + 1'b1;
      end else begin
        case (state)
          REQUEST: state <= RECEIVE;
          RECEIVE: if (rd_available) begin
            wr_index <= wr_index + 1'b1;
            if (last_word) state <= DONE;
          end
          DRAIN: if (rd_available) wr_index <= wr_index + 1'b1;
          default: ;
        endcase

        if (line_end && state != IDLE && state != DRAIN) begin
          if (last_line) begin
            char_row <= '0;
            row_cnt  <= row_next;
            if (state != DONE) begin
              underrun <= 1'b1;
            end else if (more_rows) begin
              state      <= REQUEST;
              rd_request <= 1'b1;
              rd_address <= next_row_addr(rd_address, base_q);
              wr_index   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            char_row <= char_row + 1'b1;
          end
        end
      end
    end
  end

  // Fill-bank write port: incoming SDRAM words land in the non-display bank.
  always_ff @(posedge clk) begin
    if (bank_we) bank_mem[~disp_bank][wr_index] <= rd_data;
  end

  // Display-bank read port with one cycle of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) buf_rd_data <= '0;
    else        buf_rd_data <= bank_mem[disp_bank][buf_rd_index];
  end

endmodule
